// File: rtl/winograd_pkg.sv
// rtl/winograd_pkg.sv - shared tile types, Winograd F(2x2,3x3) geometry and frame helpers
package winograd_pkg;

    localparam int TILE     = 4;
    localparam int OUT_TILE = 2;
    localparam int STRIDE   = 2;
    localparam int PIX_W    = 32;

    typedef logic [0:TILE-1][0:TILE-1][PIX_W-1:0]         tile_t;
    typedef logic [0:OUT_TILE-1][0:OUT_TILE-1][PIX_W-1:0] out_tile_t;

    // Overlapping 4x4 input tiles at stride 2 in each direction
    function automatic int tiles_per_frame(input int img_w, input int img_h);
        return (img_w / STRIDE - 1) * (img_h / STRIDE - 1);
    endfunction

endpackage

// File: rtl/tile_line_buffer.sv
// rtl/tile_line_buffer.sv - one image row of pixel storage, read-before-write at a shared address
module tile_line_buffer #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Combinational read returns the old word; the write lands at the clock edge
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/winograd_tile_feeder.sv
// rtl/winograd_tile_feeder.sv - turns a raster pixel stream into stride-2 overlapping 4x4 tiles
module winograd_tile_feeder
    import winograd_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = 32
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [DATA_W-1:0]                        pix_in,
    input  logic                                     pix_valid,
    input  logic                                     pix_sof,
    output logic [0:TILE-1][0:TILE-1][DATA_W-1:0]    tile_out,
    output logic                                     next,
    output logic [$clog2(IMG_H/2)-1:0]               tile_row,
    output logic [$clog2(IMG_W/2)-1:0]               tile_col,
    output logic                                     frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int TR_W  = $clog2(IMG_H / 2);
    localparam int TC_W  = $clog2(IMG_W / 2);

    logic [COL_W-1:0] col, cur_col, col_nxt;
    logic [ROW_W-1:0] row, cur_row, row_nxt;
    logic [DATA_W-1:0] lb0_q, lb1_q, lb2_q;
    logic [0:TILE-1][0:TILE-1][DATA_W-1:0] win, win_nxt;
    logic emit, last_pix, col_end;

    // A start-of-frame pixel is (0,0) no matter where the counters had drifted
    always_comb begin
        cur_col  = col;
        cur_row  = row;
        if (pix_valid && pix_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
        col_end  = (cur_col == COL_W'(IMG_W - 1));
        last_pix = col_end && (cur_row == ROW_W'(IMG_H - 1));
        col_nxt  = col_end ? '0 : cur_col + 1'b1;
        row_nxt  = cur_row;
        if (col_end) begin
            row_nxt = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
        end
        emit = pix_valid && (cur_row >= ROW_W'(3)) && cur_row[0]
                         && (cur_col >= COL_W'(3)) && cur_col[0];
    end

    tile_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (pix_valid),
        .addr    (cur_col),
        .wr_data (pix_in),
        .rd_data (lb0_q)
    );

    tile_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (pix_valid),
        .addr    (cur_col),
        .wr_data (lb0_q),
        .rd_data (lb1_q)
    );

    tile_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb2 (
        .clk     (clk),
        .wr_en   (pix_valid),
        .addr    (cur_col),
        .wr_data (lb1_q),
        .rd_data (lb2_q)
    );

    // Window slides left; the incoming column stacks the three older rows above the new pixel
    always_comb begin
        win_nxt = win;
        for (int r = 0; r < TILE; r++) begin
            for (int c = 0; c < TILE - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
        end
        win_nxt[0][TILE-1] = lb2_q;
        win_nxt[1][TILE-1] = lb1_q;
        win_nxt[2][TILE-1] = lb0_q;
        win_nxt[3][TILE-1] = pix_in;
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            win <= win_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            next       <= 1'b0;
            frame_done <= 1'b0;
            tile_out   <= '0;
            tile_row   <= '0;
            tile_col   <= '0;
        end else begin
            next       <= emit;
            frame_done <= emit && last_pix;
            if (pix_valid) begin
                col <= col_nxt;
                row <= row_nxt;
            end
            if (emit) begin
                tile_out <= win_nxt;
                tile_row <= TR_W'((cur_row - ROW_W'(3)) >> 1);
                tile_col <= TC_W'((cur_col - COL_W'(3)) >> 1);
            end
        end
    end

endmodule

// File: tb/tb_winograd_tile_feeder.sv
// tb/tb_winograd_tile_feeder.sv - scoreboard bench for the 8x8 tile feeder configuration
module tb_winograd_tile_feeder;
    import winograd_pkg::*;

    localparam int W = 8;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pix_in;
    logic        pix_valid;
    logic        pix_sof;
    tile_t       tile_out;
    logic        next;
    logic [1:0]  tile_row;
    logic [1:0]  tile_col;
    logic        frame_done;

    winograd_tile_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .tile_out   (tile_out),
        .next       (next),
        .tile_row   (tile_row),
        .tile_col   (tile_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        tile_t t;
        int    tr;
        int    tc;
        bit    done;
        int    at;
    } exp_t;

    typedef struct {
        tile_t t;
        int    tr;
        int    tc;
        bit    done;
    } obs_t;

    exp_t        sb[$];
    obs_t        obs[$];
    int          checks = 0;
    int          errors = 0;
    int          tile_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] img [0:H-1][0:W-1];

    task automatic monitor();
        exp_t e;
        obs_t o;
        forever begin
            @(negedge clk);
            if (next === 1'b1) begin
                tile_cnt++;
                if (frame_done === 1'b1) done_cnt++;
                o.t = tile_out; o.tr = int'(tile_row); o.tc = int'(tile_col); o.done = frame_done;
                obs.push_back(o);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_next: cycle %0d got tile_row=%0d tile_col=%0d, required no tile", cyc, tile_row, tile_col);
                end else begin
                    e = sb.pop_front();
                    if (tile_out !== e.t || tile_row !== 2'(e.tr) || tile_col !== 2'(e.tc) ||
                        frame_done !== e.done || cyc !== e.at) begin
                        errors++;
                        $display("FAIL tile_compare: got row=%0d col=%0d done=%b cyc=%0d tile=%h, required row=%0d col=%0d done=%b cyc=%0d tile=%h",
                                 tile_row, tile_col, frame_done, cyc, tile_out, e.tr, e.tc, e.done, e.at, e.t);
                    end
                end
            end else begin
                checks++;
                if (next !== 1'b0 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_strobes: cycle %0d got next=%b frame_done=%b, required 0 0", cyc, next, frame_done);
                end
            end
        end
    endtask

    task automatic drive_pixel(input int r, input int c, input logic [31:0] v, input logic sof);
        exp_t e;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_in    = v;
        pix_sof   = sof;
        img[r][c] = v;
        if (r >= 3 && r % 2 == 1 && c >= 3 && c % 2 == 1) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    e.t[i][j] = img[r-3+i][c-3+j];
            e.tr   = (r - 3) / 2;
            e.tc   = (c - 3) / 2;
            e.done = (r == H - 1) && (c == W - 1);
            e.at   = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            pix_sof   = 1'($urandom % 2);
            pix_in    = $urandom;
        end
    endtask

    task automatic drive_range(input int base, input bit sof, input bit gaps, input int n);
        int r;
        int c;
        for (int p = 0; p < n; p++) begin
            r = p / W;
            c = p % W;
            if (gaps) begin
                for (int k = 0; k < 4 && ($urandom % 2) == 1; k++) idle(1);
            end
            drive_pixel(r, c, 32'(base + 8 * r + c), sof && p == 0);
        end
    endtask

    task automatic clear_obs();
        obs.delete();
        tile_cnt = 0;
        done_cnt = 0;
    endtask

    function automatic tile_t ref_tile(input int base, input int r0, input int c0);
        tile_t t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t[i][j] = 32'(base + 8 * (r0 + i) + (c0 + j));
        return t;
    endfunction

    task automatic check_counts(input string name, input int tiles, input int dones);
        checks++;
        if (tile_cnt != tiles || done_cnt != dones) begin
            errors++;
            $display("FAIL %s_counts: got tiles=%0d frame_done=%0d, required tiles=%0d frame_done=%0d", name, tile_cnt, done_cnt, tiles, dones);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (next !== 1'b0 || frame_done !== 1'b0 || tile_out !== '0 || tile_row !== 2'd0 || tile_col !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got next=%b done=%b row=%0d col=%0d tile=%h, required all zero", next, frame_done, tile_row, tile_col, tile_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_tile();
        clear_obs();
        drive_range(0, 1, 0, W * H);
        idle(2);
        check_counts("first_frame", tiles_per_frame(W, H), 1);
        checks++;
        if (obs.size() < 9) begin
            errors++;
            $display("FAIL first_frame_size: got %0d tiles, required 9", obs.size());
        end else begin
            if (obs[0].t !== ref_tile(0, 0, 0) || obs[0].tr != 0 || obs[0].tc != 0 || obs[0].done) begin
                errors++;
                $display("FAIL first_tile: got row=%0d col=%0d tile=%h, required row=0 col=0 tile=%h", obs[0].tr, obs[0].tc, obs[0].t, ref_tile(0, 0, 0));
            end
            checks++;
            if (obs[8].t[0][0] !== 32'd36 || obs[8].tr != 2 || obs[8].tc != 2 || !obs[8].done || obs[7].done) begin
                errors++;
                $display("FAIL last_tile: got row=%0d col=%0d t00=%0d done=%b, required row=2 col=2 t00=36 done=1", obs[8].tr, obs[8].tc, obs[8].t[0][0], obs[8].done);
            end
        end
    endtask

    task automatic test_second_tile();
        idle(3);
        checks++;
        if (tile_out !== ref_tile(0, 4, 4) || tile_row !== 2'd2 || tile_col !== 2'd2) begin
            errors++;
            $display("FAIL tile_hold: got row=%0d col=%0d tile=%h, required row=2 col=2 tile=%h", tile_row, tile_col, tile_out, ref_tile(0, 4, 4));
        end
        clear_obs();
        drive_range(0, 1, 0, W * H);
        idle(2);
        check_counts("second_frame", 9, 1);
        checks++;
        if (obs.size() < 2) begin
            errors++;
            $display("FAIL second_tile_size: got %0d tiles, required at least 2", obs.size());
        end else if (obs[1].t[0][0] !== 32'd2 || obs[1].t[3][3] !== 32'd29 || obs[1].tc != 1 || obs[1].tr != 0) begin
            errors++;
            $display("FAIL second_tile: got t00=%0d t33=%0d row=%0d col=%0d, required t00=2 t33=29 row=0 col=1", obs[1].t[0][0], obs[1].t[3][3], obs[1].tr, obs[1].tc);
        end
    endtask

    task automatic test_gapped();
        clear_obs();
        drive_range(0, 1, 1, W * H);
        idle(3);
        check_counts("gapped", 9, 1);
        checks++;
        if (obs.size() < 1 || obs[0].t !== ref_tile(0, 0, 0)) begin
            errors++;
            $display("FAIL gapped_first_tile: got %0d tiles, required first tile %h", obs.size(), ref_tile(0, 0, 0));
        end
    endtask

    task automatic test_resync();
        clear_obs();
        drive_range(0, 1, 0, 5 * W + 2);
        drive_range(0, 1, 0, W * H);
        idle(2);
        check_counts("resync", 12, 1);
        checks++;
        if (obs.size() < 4 || obs[3].t !== ref_tile(0, 0, 0) || obs[3].tr != 0 || obs[3].tc != 0) begin
            errors++;
            $display("FAIL resync_first_tile: got %0d tiles, required tile 3 at (0,0) equal to %h", obs.size(), ref_tile(0, 0, 0));
        end
    endtask

    task automatic test_mid_reset();
        clear_obs();
        drive_range(0, 1, 0, 4 * W + 6);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        checks++;
        if (next !== 1'b0 || frame_done !== 1'b0 || tile_out !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got next=%b done=%b tile=%h, required 0 0 0", next, frame_done, tile_out);
        end
        reset = 1'b0;
        drive_range(0, 0, 0, W * H);
        idle(2);
        check_counts("mid_reset", 12, 1);
        checks++;
        if (obs.size() < 4 || obs[3].t !== ref_tile(0, 0, 0)) begin
            errors++;
            $display("FAIL mid_reset_first_tile: got %0d tiles, required tile 3 equal to %h", obs.size(), ref_tile(0, 0, 0));
        end
    endtask

    task automatic test_frame_wrap();
        clear_obs();
        drive_range(0, 1, 0, W * H);
        drive_range(1000, 0, 0, W * H);
        idle(2);
        check_counts("frame_wrap", 18, 2);
        checks++;
        if (obs.size() < 18 || obs[9].t !== ref_tile(1000, 0, 0) || !obs[17].done || obs[17].tr != 2 || obs[17].tc != 2) begin
            errors++;
            $display("FAIL frame_wrap_second: got %0d tiles, required tile 9 equal to %h and tile 17 ending the frame", obs.size(), ref_tile(1000, 0, 0));
        end
    endtask

    initial begin
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_in    = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_first_tile();
        test_second_tile();
        test_gapped();
        test_resync();
        test_mid_reset();
        test_frame_wrap();
        idle(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_tiles: got %0d undelivered, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/winograd_tile_feeder.md
Name: winograd_tile_feeder

Overview:
- Feeds the Winograd F(2x2,3x3) processing element.
- Accepts a single-channel feature map as a raster-order pixel stream.
- Emits overlapping 4x4 input tiles at stride 2 in both directions, each with a one-cycle next strobe that drives the PE's next input directly.
- Also emits tile coordinates and an end-of-frame strobe for the downstream output collector.

Parameters:
- IMG_W, 32, pixels per row; must be even and >= 4.
- IMG_H, 32, rows per frame; must be even and >= 4.
- DATA_W, 32, pixel width (fp32 bit pattern, passed through untouched).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active high
- pix_in  in  DATA_W  input pixel
- pix_valid  in  1  pix_in is accepted this cycle; gaps allowed, no backpressure
- pix_sof  in  1  qualified by pix_valid; marks pixel (0,0) of a frame
- tile_out  out  DATA_W x [0:3][0:3]  4x4 tile, [row][col], row 0 = oldest image row
- next  out  1  one-cycle strobe: tile_out is valid this cycle
- tile_row  out  clog2(IMG_H/2)  tile row index (top image row / 2)
- tile_col  out  clog2(IMG_W/2)  tile column index (left image column / 2)
- frame_done  out  1  one-cycle strobe, coincident with next, on the last tile of a frame

Behaviour:
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the pixel being accepted.
- Counters advance only on pix_valid; col wraps to 0 and increments row; row wraps to 0 after IMG_H-1.
- pix_sof with pix_valid: that pixel is treated as (0,0) regardless of counter state. The counters then continue from (0,1). pix_sof without pix_valid is ignored.
- Line buffers: three IMG_W-deep arrays, lb0 = row-1, lb1 = row-2, lb2 = row-3.
  - On accept at column c, all three are read at c before the write.
  - Then lb2[c]<=lb1[c], lb1[c]<=lb0[c], lb0[c]<=pix_in.
- Window: 4x4 register array. On accept it shifts left one column. The new column 3 is {lb2[c], lb1[c], lb0[c], pix_in} for rows 0..3.
- Tile emit: the accepted pixel has row>=3, row odd, col>=3, col odd.
  - Next cycle: next=1, tile_out = updated window, tile_row=(row-3)/2, tile_col=(col-3)/2.
  - Latency from accepted pixel to next is exactly 1 cycle.
- tile_out, tile_row and tile_col hold their value until the next emit. Only next and frame_done pulse.
- frame_done=1 with next when the emitting pixel is (IMG_H-1, IMG_W-1).
- Tiles per frame = (IMG_W/2-1)*(IMG_H/2-1).
- Window contents from the previous row bleed into columns 0..2 at the start of each row. They are never emitted because emit requires col>=3.
- Reset:
  - row, col, next, frame_done, tile_row, tile_col and tile_out all go to 0.
  - Line buffers and window are not cleared. Their stale data cannot be emitted before 3 fresh rows refill them.
- Reset mid-frame: the next accepted pixel is (0,0).
- The back-to-back tile rate is one every 2 accepted pixels. The PE accepts one tile per cycle, so no flow control is needed.

Decomposition:
- Package winograd_pkg holds:
  - the tile typedef tile_t (DATA_W x [0:3][0:3]) and the PE output typedef (DATA_W x [0:1][0:1]);
  - the constants TILE=4, OUT_TILE=2, STRIDE=2;
  - a function for tiles-per-frame.
- One sub-module, tile_line_buffer: a parameterised IMG_W x DATA_W register array with read-before-write at a shared address. It is instantiated three times (lb0, lb1, lb2).

Test Plan:
- First tile:
  - Stimulus: IMG_W=IMG_H=8, continuous pix_valid, pix_in = 8*r+c, pix_sof on the first pixel.
  - Response: the first next arrives the cycle after pixel (3,3), with tile_out[i][j]=8*i+j, tile_row=0, tile_col=0.
  - Exactly 9 next pulses per frame; frame_done only on the 9th, with tile_row=2, tile_col=2 and tile_out[0][0]=36.
- Second tile:
  - Stimulus: same frame.
  - Response: the second next follows pixel (3,5), with tile_out[0][0]=2, tile_out[3][3]=29, tile_col=1.
  - tile_out holds its value while next=0.
- Gapped input:
  - Stimulus: same stream with pix_valid deasserted randomly (about 50%).
  - Response: identical tile sequence and values; each next lands exactly 1 cycle after the completing pixel.
- Resync:
  - Stimulus: pix_sof asserted at frame position (5,2).
  - Response: the counters resync; the following 8x8 frame produces 9 tiles with the first-tile values from the first-tile scenario.
  - No spurious next on rows 0–2 of the new frame.
- Mid-frame reset:
  - Stimulus: assert reset for 1 cycle at pixel (4,6), then restart the frame.
  - Response: next, frame_done and tile_out are 0 the cycle after reset.
  - The new frame yields tiles bit-exact with the first-tile scenario.
- Frame wrap:
  - Stimulus: two back-to-back frames without pix_sof.
  - Response: row/col wrap; the second frame yields 9 tiles; frame_done pulses twice.
